// File: rtl/hex_scan_display.sv
// Four-digit multiplexed hex display driver for a common-anode 7-segment panel.
// Double-buffered word/dp/blank with frame-boundary commit and PWM brightness.
module hex_scan_display #(
   parameter int unsigned REFRESH_DVSR = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] hex_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic        load,
   input  logic [2:0]  bright,
   output logic [3:0]  an,
   output logic [7:0]  sseg,
   output logic        frame_tick
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DVSR);
   localparam int unsigned SLOT  = REFRESH_DVSR / 8;

   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [1:0]       digit_q, digit_d;
   logic [15:0]      activeHex_q, activeHex_d, pendHex_q, pendHex_d;
   logic [3:0]       activeDp_q, activeDp_d, pendDp_q, pendDp_d;
   logic [3:0]       activeBlank_q, activeBlank_d, pendBlank_q, pendBlank_d;
   logic             pendValid_q, pendValid_d;
   logic [3:0]       an_q, an_d;
   logic [7:0]       sseg_q, sseg_d;
   logic             frameTick_q, frameTick_d;

   logic             dwellEnd, frameEnd;
   logic [3:0]       nibble;
   logic [6:0]       segs;
   logic [31:0]      onLimit;
   logic             lit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dwell_q       <= '0;
         digit_q       <= '0;
         activeHex_q   <= '0;
         activeDp_q    <= '0;
         activeBlank_q <= 4'hF;
         pendHex_q     <= '0;
         pendDp_q      <= '0;
         pendBlank_q   <= '0;
         pendValid_q   <= 1'b0;
         an_q          <= 4'hF;
         sseg_q        <= 8'hFF;
         frameTick_q   <= 1'b0;
      end else begin
         dwell_q       <= dwell_d;
         digit_q       <= digit_d;
         activeHex_q   <= activeHex_d;
         activeDp_q    <= activeDp_d;
         activeBlank_q <= activeBlank_d;
         pendHex_q     <= pendHex_d;
         pendDp_q      <= pendDp_d;
         pendBlank_q   <= pendBlank_d;
         pendValid_q   <= pendValid_d;
         an_q          <= an_d;
         sseg_q        <= sseg_d;
         frameTick_q   <= frameTick_d;
      end
   end

   // A load landing on the boundary cycle bypasses the pending buffer entirely.
   always_comb begin
      dwellEnd      = (dwell_q == CNT_W'(REFRESH_DVSR - 1));
      frameEnd      = dwellEnd && (digit_q == 2'd3);
      dwell_d       = dwellEnd ? '0 : dwell_q + CNT_W'(1);
      digit_d       = dwellEnd ? digit_q + 2'd1 : digit_q;
      activeHex_d   = activeHex_q;
      activeDp_d    = activeDp_q;
      activeBlank_d = activeBlank_q;
      pendHex_d     = pendHex_q;
      pendDp_d      = pendDp_q;
      pendBlank_d   = pendBlank_q;
      pendValid_d   = pendValid_q;
      frameTick_d   = 1'b0;
      if (frameEnd && load) begin
         activeHex_d   = hex_in;
         activeDp_d    = dp_in;
         activeBlank_d = blank_in;
         pendValid_d   = 1'b0;
         frameTick_d   = 1'b1;
      end else if (frameEnd && pendValid_q) begin
         activeHex_d   = pendHex_q;
         activeDp_d    = pendDp_q;
         activeBlank_d = pendBlank_q;
         pendValid_d   = 1'b0;
         frameTick_d   = 1'b1;
      end else if (load) begin
         pendHex_d   = hex_in;
         pendDp_d    = dp_in;
         pendBlank_d = blank_in;
         pendValid_d = 1'b1;
      end
   end

   always_comb begin
      nibble = activeHex_q[{digit_q, 2'b00} +: 4];
      case (nibble)
         4'h0:    segs = 7'b1000000;
         4'h1:    segs = 7'b1111001;
         4'h2:    segs = 7'b0100100;
         4'h3:    segs = 7'b0110000;
         4'h4:    segs = 7'b0011001;
         4'h5:    segs = 7'b0010010;
         4'h6:    segs = 7'b0000010;
         4'h7:    segs = 7'b1111000;
         4'h8:    segs = 7'b0000000;
         4'h9:    segs = 7'b0010000;
         4'hA:    segs = 7'b0001000;
         4'hB:    segs = 7'b0000011;
         4'hC:    segs = 7'b1000110;
         4'hD:    segs = 7'b0100001;
         4'hE:    segs = 7'b0000110;
         default: segs = 7'b0001110;
      endcase
   end

   // Brightness gates the first (bright+1)/8 of each dwell; bright is used live.
   always_comb begin
      onLimit = (32'(bright) + 32'd1) * SLOT;
      lit     = (32'(dwell_q) < onLimit) && !activeBlank_q[digit_q];
      an_d    = lit ? ~(4'b0001 << digit_q) : 4'hF;
      sseg_d  = lit ? {~activeDp_q[digit_q], segs} : 8'hFF;
   end

   assign an         = an_q;
   assign sseg       = sseg_q;
   assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with a cycle-level scoreboard model
// plus targeted scenario checks (commit, bypass, blanking, brightness, reset).
module tb_hex_scan_display;

   localparam int unsigned DVSR = 16;
   localparam int unsigned SLOTS = DVSR / 8;

   logic        clk;
   logic        reset_n;
   logic [15:0] hex_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        load;
   logic [2:0]  bright;
   logic [3:0]  an;
   logic [7:0]  sseg;
   logic        frame_tick;

   int checks;
   int failures;
   int ftCount;
   bit watch1111;
   bit seen1111;

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] sseg;
      logic       ft;
   } exp_t;

   exp_t sb[$];

   int          mDwell;
   int          mDigit;
   logic [15:0] mHex, pHex;
   logic [3:0]  mDp, pDp, mBlank, pBlank;
   bit          pValid;

   hex_scan_display #(.REFRESH_DVSR(DVSR)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .hex_in(hex_in),
      .dp_in(dp_in),
      .blank_in(blank_in),
      .load(load),
      .bright(bright),
      .an(an),
      .sseg(sseg),
      .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] segOf(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
         4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
         4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
         4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
      endcase
      return s;
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
      hex_in   = h;
      dp_in    = d;
      blank_in = b;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   task automatic waitFrameTick(input int maxCycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < maxCycles);
      checkOutput("ftWait", {7'b0, frame_tick}, 8'h01);
   endtask

   // Reference model: predicts registered outputs for the next cycle.
   always @(posedge clk) begin
      exp_t e;
      bit   lit, boundary;
      if (reset_n !== 1'b1) begin
         mDwell = 0; mDigit = 0; mHex = '0; mDp = '0; mBlank = 4'hF;
         pHex = '0; pDp = '0; pBlank = '0; pValid = 0;
         sb.delete();
      end else begin
         lit      = (mDwell < (int'(bright) + 1) * SLOTS) && !mBlank[mDigit];
         e.an     = lit ? ~(4'b0001 << mDigit) : 4'hF;
         e.sseg   = lit ? {~mDp[mDigit], segOf(mHex[mDigit*4 +: 4])} : 8'hFF;
         boundary = (mDwell == DVSR - 1) && (mDigit == 3);
         e.ft     = boundary && (load || pValid);
         sb.push_back(e);
         if (boundary && load) begin
            mHex = hex_in; mDp = dp_in; mBlank = blank_in; pValid = 0;
         end else if (boundary && pValid) begin
            mHex = pHex; mDp = pDp; mBlank = pBlank; pValid = 0;
         end else if (load) begin
            pHex = hex_in; pDp = dp_in; pBlank = blank_in; pValid = 1;
         end
         if (mDwell == DVSR - 1) mDigit = (mDigit + 1) % 4;
         mDwell = (mDwell + 1) % DVSR;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset_n !== 1'b1) begin
         sb.delete();
         checkOutput("rstAn", {4'b0, an}, 8'h0F);
         checkOutput("rstSseg", sseg, 8'hFF);
         checkOutput("rstFt", {7'b0, frame_tick}, 8'h00);
      end else if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("an", {4'b0, an}, {4'b0, e.an});
         checkOutput("sseg", sseg, e.sseg);
         checkOutput("ft", {7'b0, frame_tick}, {7'b0, e.ft});
         checkOutput("oneAnode", {7'b0, ($countones(~an) <= 1)}, 8'h01);
         if (frame_tick === 1'b1) ftCount++;
         if (watch1111 && an === 4'b1110 && sseg[6:0] === 7'h79) seen1111 = 1;
      end
   end

   initial begin
      int cnt0, cnt1, cnt2, cnt3, litCnt;
      checks = 0; failures = 0; ftCount = 0; watch1111 = 0; seen1111 = 0;
      reset_n = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0; load = 1'b0; bright = 3'd7;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // No load: nothing is ever committed.
      repeat (70) @(negedge clk);
      checkOutput("noLoadFt", 8'(ftCount), 8'd0);

      applyStimulus(16'h12AF, 4'b0001, 4'b0000);
      waitFrameTick(100);
      cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         case (an)
            4'b1110: begin cnt0++; checkOutput("dig0", sseg, 8'h0E); end
            4'b1101: begin cnt1++; checkOutput("dig1", sseg, 8'h88); end
            4'b1011: begin cnt2++; checkOutput("dig2", sseg, 8'hA4); end
            4'b0111: begin cnt3++; checkOutput("dig3", sseg, 8'hF9); end
            default: checkOutput("anLit", {4'b0, an}, 8'h00);
         endcase
      end
      checkOutput("cnt0", 8'(cnt0), 8'd16);
      checkOutput("cnt1", 8'(cnt1), 8'd16);
      checkOutput("cnt2", 8'(cnt2), 8'd16);
      checkOutput("cnt3", 8'(cnt3), 8'd16);

      // Mid-frame double load: only the last word reaches the display.
      repeat (20) @(negedge clk);
      ftCount = 0;
      watch1111 = 1;
      applyStimulus(16'h1111, 4'b0000, 4'b0000);
      repeat (9) @(negedge clk);
      applyStimulus(16'h2222, 4'b0000, 4'b0000);
      waitFrameTick(100);
      repeat (2) @(negedge clk);
      checkOutput("oneTick", 8'(ftCount), 8'd1);
      for (int i = 0; i < 61; i++) begin
         @(negedge clk);
         if (an !== 4'hF) checkOutput("show2222", {1'b0, sseg[6:0]}, 8'h24);
      end
      checkOutput("never1111", {7'b0, seen1111}, 8'h00);
      watch1111 = 0;

      // Load exactly on the boundary cycle takes the bypass path.
      applyStimulus(16'h8888, 4'b0000, 4'b0000);
      checkOutput("ftBypass", {7'b0, frame_tick}, 8'h01);
      litCnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (an !== 4'hF) begin
            litCnt++;
            checkOutput("show8888", {1'b0, sseg[6:0]}, 8'h00);
         end
      end
      checkOutput("lit8888", 8'(litCnt), 8'd64);

      bright = 3'd1;
      repeat (2) @(negedge clk);
      litCnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (an !== 4'hF) litCnt++;
      end
      checkOutput("bright1", 8'(litCnt), 8'd16);

      bright = 3'd0;
      repeat (2) @(negedge clk);
      litCnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (an !== 4'hF) litCnt++;
      end
      checkOutput("bright0", 8'(litCnt), 8'd8);

      bright = 3'd7;
      applyStimulus(16'hFFFF, 4'b0000, 4'b1010);
      waitFrameTick(100);
      litCnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         checkOutput("blankAn", {6'b0, an[3], an[1]}, 8'h03);
         if (an !== 4'hF) litCnt++;
      end
      checkOutput("litBlank", 8'(litCnt), 8'd32);

      // Asynchronous reset between clock edges.
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("asyncAn", {4'b0, an}, 8'h0F);
      checkOutput("asyncSseg", sseg, 8'hFF);
      checkOutput("asyncFt", {7'b0, frame_tick}, 8'h00);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
